// File: rtl/psum_mem_arb.sv
// psum_mem_arb: shares the partial-sum memory read port between the streaming
// accumulator (absolute priority) and a burst drain engine with a credit-
// limited output FIFO. The accumulator write port is a straight pass-through.
module psum_mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] acc_radd,
  input  logic                  acc_rden,
  output logic [DATA_WIDTH-1:0] acc_odat,
  output logic                  acc_ovld,
  input  logic [ADDR_WIDTH-1:0] acc_wadd,
  input  logic                  acc_wren,
  input  logic [DATA_WIDTH-1:0] acc_idat,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_ovld,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic                  drn_start,
  input  logic [ADDR_WIDTH-1:0] drn_base,
  input  logic [REG_WIDTH-1:0]  drn_len,
  output logic [DATA_WIDTH-1:0] drn_odat,
  output logic                  drn_ovld,
  input  logic                  drn_ordy,
  output logic                  drn_busy,
  output logic                  drn_done,
  output logic [REG_WIDTH-1:0]  dbg_drn_issue_cnt,
  output logic [REG_WIDTH-1:0]  dbg_drn_stall_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] drn_addr;
  logic [REG_WIDTH-1:0]  len, issued, stall_cnt;
  logic [MEM_DELAY-1:0]  tag_pipe;
  logic                  tag_out;
  logic [CW-1:0]         inflight, fifo_cnt, fifo_cnt_nxt;
  logic [CW:0]           credit_used;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  more, drn_issue, push, pop;

  // Write path is untouched; the drain never writes.
  assign mem_wadd = acc_wadd;
  assign mem_wren = acc_wren;
  assign mem_idat = acc_idat;

  // Issue gating: reads in flight plus words buffered may not exceed the FIFO,
  // so a return always has a slot. Same-cycle pops are deliberately not credited.
  assign more        = issued < len;
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign drn_issue   = (state == RUN) & ~acc_rden & more &
                       (credit_used < (CW+1)'(FIFO_DEPTH));

  assign mem_rden = acc_rden | drn_issue;
  assign mem_radd = acc_rden ? acc_radd : drn_addr;

  // Returns tagged 0 belong to the accumulator; tagged 1 go to the drain FIFO.
  assign tag_out  = tag_pipe[MEM_DELAY-1];
  assign acc_ovld = mem_ovld & ~tag_out;
  assign acc_odat = mem_odat;
  assign push     = mem_ovld & tag_out;

  assign drn_ovld     = (fifo_cnt != '0);
  assign drn_odat     = fifo_mem[rd_ptr];
  assign pop          = drn_ovld & drn_ordy;
  assign fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);

  assign drn_busy          = (state != IDLE);
  assign drn_done          = (state == DONE);
  assign dbg_drn_issue_cnt = issued;
  assign dbg_drn_stall_cnt = stall_cnt;

  // Drain FSM with burst address, length and debug counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drn_addr  <= '0;
      len       <= '0;
      issued    <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (drn_start) begin
          len       <= drn_len;
          drn_addr  <= drn_base;
          issued    <= '0;
          stall_cnt <= '0;
          state     <= (drn_len == '0) ? DONE : RUN;
        end
        RUN: begin
          if (drn_issue) begin
            drn_addr <= drn_addr + ADDR_WIDTH'(1);
            issued   <= issued + REG_WIDTH'(1);
          end
          if (acc_rden && more) stall_cnt <= stall_cnt + REG_WIDTH'(1);
          if (!more) state <= FLUSH;
        end
        // Only leave once nothing is in flight and the last word pops now.
        FLUSH: if (inflight == '0 && fifo_cnt_nxt == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return tag pipe, in-flight count and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      tag_pipe[0] <= drn_issue;
      for (int k = 1; k < MEM_DELAY; k++) tag_pipe[k] <= tag_pipe[k-1];
      inflight <= inflight + CW'(drn_issue) - CW'(tag_out);
      fifo_cnt <= fifo_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_odat;
  end

endmodule

// File: tb/tb_psum_mem_arb.sv
// Directed bench for psum_mem_arb with a one-cycle-latency memory model.
module tb_psum_mem_arb;

  logic        clk = 0, rst_n = 0;
  logic [31:0] acc_radd = 0, acc_wadd = 0, acc_idat = 0;
  logic        acc_rden = 0, acc_wren = 0;
  logic [31:0] acc_odat, mem_radd, mem_wadd, mem_idat;
  logic        acc_ovld, mem_rden, mem_wren;
  logic [31:0] mem_odat = 0;
  logic        mem_ovld = 0;
  logic        drn_start = 0, drn_ordy = 0;
  logic [31:0] drn_base = 0, drn_len = 0;
  logic [31:0] drn_odat, dbg_drn_issue_cnt, dbg_drn_stall_cnt;
  logic        drn_ovld, drn_busy, drn_done;

  int n_chk = 0, n_err = 0;

  psum_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .acc_radd(acc_radd), .acc_rden(acc_rden), .acc_odat(acc_odat), .acc_ovld(acc_ovld),
    .acc_wadd(acc_wadd), .acc_wren(acc_wren), .acc_idat(acc_idat),
    .mem_radd(mem_radd), .mem_rden(mem_rden), .mem_odat(mem_odat), .mem_ovld(mem_ovld),
    .mem_wadd(mem_wadd), .mem_wren(mem_wren), .mem_idat(mem_idat),
    .drn_start(drn_start), .drn_base(drn_base), .drn_len(drn_len),
    .drn_odat(drn_odat), .drn_ovld(drn_ovld), .drn_ordy(drn_ordy),
    .drn_busy(drn_busy), .drn_done(drn_done),
    .dbg_drn_issue_cnt(dbg_drn_issue_cnt), .dbg_drn_stall_cnt(dbg_drn_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory model: fixed one-cycle read latency, data is a function of address.
  always @(posedge clk) begin
    mem_ovld <= mem_rden;
    mem_odat <= fdat(mem_radd);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_iss, idx;
    logic seen_done;

    // Reset state
    nxt(); smp();
    chk("rst_busy", drn_busy, 0);
    chk("rst_ovld", drn_ovld, 0);
    chk("rst_done", drn_done, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_radd", mem_radd, 0);
    chk("rst_icnt", dbg_drn_issue_cnt, 0);
    acc_wadd = 32'h33; acc_wren = 1; acc_idat = 32'h1234_5678;
    nxt(); rst_n = 1; smp();
    chk("wr_pass_add", mem_wadd, 32'h33);
    chk("wr_pass_dat", mem_idat, 32'h1234_5678);
    chk("wr_pass_en",  mem_wren, 1);
    acc_wren = 0;

    // Test 1: drain only, base 0x10, len 4
    nxt(); drn_base = 32'h10; drn_len = 4; drn_start = 1; drn_ordy = 1; smp();
    chk("t1_busy0", drn_busy, 0);
    for (int k = 1; k <= 8; k++) begin
      nxt(); drn_start = 0; smp();
      chk("t1_rden", mem_rden, (k >= 1 && k <= 4));
      if (k <= 4) chk("t1_radd", mem_radd, 32'h10 + k - 1);
      chk("t1_ovld", drn_ovld, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("t1_odat", drn_odat, fdat(32'h10 + k - 3));
      chk("t1_done", drn_done, k == 7);
      chk("t1_busy", drn_busy, k <= 7);
    end

    // Test 2: accumulator contention at t+2..t+4
    nxt(); drn_base = 32'h10; drn_len = 4; drn_start = 1; smp();
    for (int k = 1; k <= 11; k++) begin
      nxt(); drn_start = 0;
      acc_rden = (k >= 2 && k <= 4);
      acc_radd = 32'h100 + k;
      smp();
      chk("t2_rden", mem_rden, k <= 7);
      if (k == 1) chk("t2_radd", mem_radd, 32'h10);
      else if (k <= 4) chk("t2_radd_acc", mem_radd, 32'h100 + k);
      else if (k <= 7) chk("t2_radd", mem_radd, 32'h11 + k - 5);
      chk("t2_aovld", acc_ovld, (k >= 3 && k <= 5));
      if (k >= 3 && k <= 5) chk("t2_aodat", acc_odat, fdat(32'h100 + k - 1));
      chk("t2_dovld", drn_ovld, (k == 3) || (k >= 7 && k <= 9));
      if (k == 3) chk("t2_dodat", drn_odat, fdat(32'h10));
      if (k >= 7 && k <= 9) chk("t2_dodat", drn_odat, fdat(32'h11 + k - 7));
      chk("t2_done", drn_done, k == 10);
    end
    acc_rden = 0;
    chk("t2_stall", dbg_drn_stall_cnt, 3);
    chk("t2_icnt", dbg_drn_issue_cnt, 4);

    // Test 3: backpressure, len 8 with depth-4 FIFO
    nxt(); drn_base = 32'h40; drn_len = 8; drn_start = 1; drn_ordy = 0; smp();
    n_iss = 0;
    for (int k = 0; k < 12; k++) begin
      nxt(); drn_start = 0; smp();
      if (mem_rden) n_iss++;
    end
    chk("t3_iss_held", n_iss, 4);
    chk("t3_icnt_held", dbg_drn_issue_cnt, 4);
    chk("t3_ovld_held", drn_ovld, 1);
    idx = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      nxt(); drn_ordy = 1; smp();
      if (mem_rden) n_iss++;
      if (drn_ovld) begin
        chk("t3_odat", drn_odat, fdat(32'h40 + idx));
        idx++;
      end
      if (drn_done) seen_done = 1;
    end
    chk("t3_words", idx, 8);
    chk("t3_iss", n_iss, 8);
    chk("t3_done", seen_done, 1);

    // Test 4: zero-length burst
    nxt(); nxt(); drn_base = 32'h80; drn_len = 0; drn_start = 1; smp();
    chk("t4_rden0", mem_rden, 0);
    nxt(); drn_start = 0; smp();
    chk("t4_done", drn_done, 1);
    chk("t4_busy", drn_busy, 1);
    chk("t4_rden1", mem_rden, 0);
    nxt(); smp();
    chk("t4_idle", drn_busy, 0);
    chk("t4_done_clr", drn_done, 0);
    chk("t4_rden2", mem_rden, 0);
    chk("t4_icnt", dbg_drn_issue_cnt, 0);

    // Test 5: re-pulse start in RUN with another base is ignored
    nxt(); drn_base = 32'h20; drn_len = 3; drn_start = 1; smp();
    n_iss = 0; idx = 0; seen_done = 0;
    for (int k = 1; k <= 20 && !seen_done; k++) begin
      nxt();
      drn_start = (k == 1);
      if (k == 1) begin drn_base = 32'h90; drn_len = 5; end
      smp();
      if (mem_rden) begin
        chk("t5_radd", mem_radd, 32'h20 + n_iss);
        n_iss++;
      end
      if (drn_ovld) begin
        chk("t5_odat", drn_odat, fdat(32'h20 + idx));
        idx++;
      end
      if (drn_done) seen_done = 1;
    end
    drn_start = 0;
    chk("t5_iss", n_iss, 3);
    chk("t5_words", idx, 3);
    chk("t5_icnt", dbg_drn_issue_cnt, 3);
    chk("t5_done", seen_done, 1);

    // Test 6: reset during FLUSH with two words buffered
    nxt(); nxt(); drn_base = 32'h50; drn_len = 2; drn_start = 1; drn_ordy = 0; smp();
    for (int k = 1; k <= 4; k++) begin
      nxt(); drn_start = 0; smp();
    end
    chk("t6_pre_ovld", drn_ovld, 1);
    chk("t6_pre_busy", drn_busy, 1);
    chk("t6_pre_icnt", dbg_drn_issue_cnt, 2);
    nxt(); rst_n = 0; #1;
    chk("t6_rst_ovld", drn_ovld, 0);
    chk("t6_rst_busy", drn_busy, 0);
    chk("t6_rst_done", drn_done, 0);
    chk("t6_rst_icnt", dbg_drn_issue_cnt, 0);
    chk("t6_rst_scnt", dbg_drn_stall_cnt, 0);
    nxt(); rst_n = 1; drn_ordy = 1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t6_post_ovld", drn_ovld, 0);
      chk("t6_post_busy", drn_busy, 0);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/psum_mem_arb.md
# psum_mem_arb

Read-port arbiter and drain sequencer for the partial-sum memory controller. It shares the memory read port between the partial-sum accumulator, which streams and cannot stall, and a drain engine. The drain engine reads back a contiguous burst of accumulated outputs for the host/DMA path with ready/valid backpressure. It sits between the accumulator controller and memctrl0, and passes the accumulator's write port straight through.

## Interface
- DATA_WIDTH, 32, memory word width (4 packed 8-bit psums)
- ADDR_WIDTH, 32, memory address width
- REG_WIDTH, 32, burst-length and debug-counter width
- MEM_DELAY, 1, cycles from mem_rden to the matching mem_ovld (fixed, ≥1)
- FIFO_DEPTH, 4, drain output buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- acc_radd/acc_rden  in  ADDR_WIDTH/1  accumulator read request
- acc_odat/acc_ovld  out  DATA_WIDTH/1  accumulator read return
- acc_wadd/acc_wren/acc_idat  in  ADDR_WIDTH/1/DATA_WIDTH  accumulator write
- mem_radd/mem_rden  out  ADDR_WIDTH/1  memory read port
- mem_odat/mem_ovld  in  DATA_WIDTH/1  memory read return
- mem_wadd/mem_wren/mem_idat  out  ADDR_WIDTH/1/DATA_WIDTH  memory write port
- drn_start  in  1  pulse; latch drn_base/drn_len
- drn_base  in  ADDR_WIDTH  first drain address
- drn_len  in  REG_WIDTH  words to drain
- drn_odat/drn_ovld  out  DATA_WIDTH/1  drain data stream
- drn_ordy  in  1  downstream ready
- drn_busy  out  1  engine not IDLE
- drn_done  out  1  one-cycle completion pulse
- dbg_drn_issue_cnt  out  REG_WIDTH  drain reads issued in the current burst
- dbg_drn_stall_cnt  out  REG_WIDTH  RUN cycles where the drain was blocked by acc_rden

## Operation
- Write port: combinational pass-through, mem_w* = acc_w*. The drain never writes.
- Read port arbitration: the accumulator has absolute priority.
  - mem_rden = acc_rden | drn_issue.
  - mem_radd = acc_rden ? acc_radd : drn_addr.
- drn_issue = (state==RUN) & ~acc_rden & (issued < len) & (inflight + fifo_cnt < FIFO_DEPTH). Pops in the same cycle are not credited.
- Tag pipe: a MEM_DELAY-deep shift register carries 1 for a drain read and 0 otherwise. The tag at the output pairs with mem_ovld.
  - Tag 0: acc_ovld = mem_ovld and acc_odat = mem_odat, combinational.
  - Tag 1: push mem_odat into the FIFO. acc_ovld stays 0.
- inflight counts tag-1 entries in the pipe.
- FIFO: drn_ovld = ~empty, drn_odat = head. Pop on drn_ovld & drn_ordy.
- drn_addr increments by 1 per issue and wraps modulo 2^ADDR_WIDTH.
- FSM:
  - IDLE: on drn_start, latch base/len, clear issued and both dbg counters. Go to RUN, or to DONE if drn_len==0.
  - RUN: issue reads. When issued==len, go to FLUSH.
  - FLUSH: wait until inflight==0 and FIFO empty, then go to DONE.
  - DONE: drn_done=1 for one cycle, then go to IDLE.
- drn_start outside IDLE is ignored.
- drn_busy = (state != IDLE).
- dbg_drn_stall_cnt increments in RUN when acc_rden=1 and issued<len. Both counters hold their value after DONE.
- Simultaneous events:
  - A FIFO push and pop in the same cycle leave the count unchanged.
  - If acc_rden and the drain are both eligible, the accumulator wins and the drain address holds.
- Reset (rst_n low, any time):
  - State goes to IDLE.
  - FIFO, tags, counters, drn_addr, issued and inflight are cleared.
  - Outputs:
    - mem_rden=0 and mem_radd=0 unless acc_rden=1.
    - drn_ovld=0, drn_busy=0, drn_done=0.
    - acc_ovld follows mem_ovld (tag 0).

## Timing
- drn_start at cycle t: drn_busy=1 at t+1, and the first possible issue is at t+1.
- A read issued at cycle i returns on mem_ovld at i+MEM_DELAY, is written to the FIFO at the end of that cycle, and shows as drn_ovld at i+MEM_DELAY+1.
- Last pop at cycle p: FLUSH→DONE at p+1, so drn_done=1 at p+1. IDLE and drn_busy=0 at p+2.
- drn_len=0 with drn_start at t: drn_done at t+1, drn_busy=0 at t+2.
- Accumulator read latency through the block is 0 added cycles.

## Test plan
- Drain only, MEM_DELAY=1, base=0x10, len=4, ordy=1, start at t: mem_rden t+1..t+4 with radd 0x10..0x13; drn_ovld t+3..t+6 with data in order; drn_done at t+7.
- Contention: same burst with acc_rden=1 at t+2..t+4. Required response:
  - mem_radd = acc_radd in t+2..t+4.
  - Drain addresses 0x11..0x13 issue at t+5..t+7.
  - acc_ovld only for the accumulator returns.
  - dbg_drn_stall_cnt=3.
- Backpressure: len=8, FIFO_DEPTH=4, ordy=0. Exactly 4 issues, then drn_issue stays 0. Raise ordy: the remaining 4 issue, all 8 words are delivered in address order, and none are lost.
- drn_len=0: drn_done at t+1, and no drain read (tag-1) ever issues.
- drn_start re-pulsed in RUN with a different base: ignored, and the original burst completes unchanged.
- rst_n low during FLUSH with the FIFO holding 2 words: drn_ovld, drn_busy, drn_done and the debug counters go to 0 asynchronously. After release there is no drn_ovld until a new start.
